// File: rtl/maria_pkg.sv
// maria_pkg: shared constants, timing record and palette contents for the Maria video output path.
package maria_pkg;
    localparam int PAL_DEPTH  = 512;
    localparam int PAL_AW     = $clog2(PAL_DEPTH);
    localparam int LINE_CNT_W = 10;
    localparam int PIPE_LAT   = 2;
    localparam logic [LINE_CNT_W-1:0] LINE_MAX = '1;

    typedef struct packed {
        logic hs;
        logic vs;
        logic hb;
        logic vb;
    } timing_t;

    // Lower half NTSC, upper half PAL; luma sets brightness, hue tints each channel.
    function automatic logic [23:0] palette_entry(input logic [PAL_AW-1:0] a);
        logic [7:0] y, off;
        y   = {a[3:0], a[3:0]};
        off = a[8] ? 8'h18 : 8'h00;
        return {y ^ ({a[7:4], 4'h0} + off),
                y ^ ({1'b0, a[7:4], 3'h0} + off),
                y ^ ({2'b0, a[7:4], 2'h0} + off)};
    endfunction
endpackage

// File: rtl/maria_palette_rom.sv
// maria_palette_rom: synchronous 512x24 colour lookup, NTSC half then PAL half.
module maria_palette_rom
    import maria_pkg::*;
(
    input  logic              clk,
    input  logic [PAL_AW-1:0] addr,
    output logic [23:0]       data
);
    always_ff @(posedge clk)
        data <= palette_entry(addr);
endmodule

// File: rtl/maria_video_out.sv
// maria_video_out: captures Maria pixels on mclk0, maps them through the palette and
// emits RGB with aligned timing two clocks later, plus frame line statistics.
module maria_video_out
    import maria_pkg::*;
(
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  mclk0,
    input  logic [7:0]            YC,
    input  logic                  hsync,
    input  logic                  vsync,
    input  logic                  hblank,
    input  logic                  vblank,
    input  logic                  PAL,
    output logic                  ce_pix,
    output logic [7:0]            R,
    output logic [7:0]            G,
    output logic [7:0]            B,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  hblank_o,
    output logic                  vblank_o,
    output logic                  de,
    output logic [LINE_CNT_W-1:0] lines_per_frame,
    output logic                  frame_odd,
    output logic                  timing_stable
);
    timing_t                 s0_t, s1_t;
    logic [7:0]              s0_yc;
    logic                    s0_pal, s0_vld, s1_vld;
    logic [23:0]             rgb;
    logic [LINE_CNT_W-1:0]   line_cnt;
    logic                    hs_rise, vs_rise;

    // Edges are taken against the previous captured sample, so they only exist on mclk0.
    assign hs_rise = hsync & ~s0_t.hs;
    assign vs_rise = vsync & ~s0_t.vs;

    maria_palette_rom u_rom (
        .clk  (clk_sys),
        .addr ({s0_pal, s0_yc}),
        .data (rgb)
    );

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            s0_vld <= 1'b0;
            s0_yc  <= '0;
            s0_pal <= 1'b0;
            s0_t   <= '0;
            s1_vld <= 1'b0;
            s1_t   <= '0;
        end else begin
            s0_vld <= mclk0;
            s1_vld <= s0_vld;
            s1_t   <= s0_t;
            if (mclk0) begin
                s0_yc  <= YC;
                s0_pal <= PAL;
                s0_t   <= '{hs: hsync, vs: vsync, hb: hblank, vb: vblank};
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            ce_pix   <= 1'b0;
            {R, G, B} <= '0;
            hsync_o  <= 1'b0;
            vsync_o  <= 1'b0;
            hblank_o <= 1'b1;
            vblank_o <= 1'b1;
            de       <= 1'b0;
        end else begin
            ce_pix <= s1_vld;
            if (s1_vld) begin
                {R, G, B} <= (s1_t.hb | s1_t.vb) ? 24'h0 : rgb;
                hsync_o   <= s1_t.hs;
                vsync_o   <= s1_t.vs;
                hblank_o  <= s1_t.hb;
                vblank_o  <= s1_t.vb;
                de        <= ~(s1_t.hb | s1_t.vb);
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            line_cnt        <= '0;
            lines_per_frame <= '0;
            frame_odd       <= 1'b0;
            timing_stable   <= 1'b0;
        end else if (mclk0) begin
            if (vs_rise) begin
                lines_per_frame <= line_cnt;
                line_cnt        <= '0;
                frame_odd       <= ~frame_odd;
                timing_stable   <= (line_cnt == lines_per_frame) && (line_cnt != '0);
            end else if (hs_rise && line_cnt != LINE_MAX) begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end
endmodule
